// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Registered, flow-controlled immediate decoder between fetch and
// register-read/execute. Decodes the base RV32I/RV64I immediate formats
// (I, S, B, J, U), sign-extends to XLEN, flags and counts illegal opcodes,
// and moves results under a valid/ready handshake with an optional skid entry.
//
// Parameters
//   XLEN      immediate output width (32 or 64)
//   USE_SKID  1: output reg + skid reg, registered o_Ready
//             0: output reg only, o_Ready = !o_Valid || i_Ready
// Ports
//   i_Clk, i_Rst_n        clock, async active-low reset
//   i_Valid/o_Ready/i_Instr  upstream handshake and instruction word
//   o_Valid/i_Ready          downstream handshake
//   o_Instr, o_Imm, o_ImmSrc, o_Illegal  decoded result
//   o_IllegalCnt          saturating count of delivered illegal results
module imm_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          USE_SKID = 1'b1
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic [31:0]     i_Instr,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [31:0]     o_Instr,
    output logic [XLEN-1:0] o_Imm,
    output logic [2:0]      o_ImmSrc,
    output logic            o_Illegal,
    output logic [15:0]     o_IllegalCnt
);

    localparam int unsigned IW = 32;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 16;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OPIMM  = 7'd19;
    localparam logic [6:0] OPC_AUIPC  = 7'd23;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_LUI    = 7'd55;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JALR   = 7'd103;
    localparam logic [6:0] OPC_JAL    = 7'd111;

    localparam logic [SW-1:0] SRC_I    = 3'b000;
    localparam logic [SW-1:0] SRC_S    = 3'b001;
    localparam logic [SW-1:0] SRC_B    = 3'b010;
    localparam logic [SW-1:0] SRC_J    = 3'b011;
    localparam logic [SW-1:0] SRC_U    = 3'b100;
    localparam logic [SW-1:0] SRC_NONE = 3'b111;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    // One pipeline entry: everything the stage hands downstream
    typedef struct packed {
        logic [IW-1:0]   instr;
        logic [XLEN-1:0] imm;
        logic [SW-1:0]   src;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instr: '0, imm: '0, src: SRC_NONE, illegal: 1'b0};

    entry_t        dec;
    entry_t        out_q, out_d;
    entry_t        skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_fire;
    logic          out_fire;
    logic [IW-1:0] imm32;

    // Immediate decode of the incoming instruction (32-bit form first)
    always_comb begin
        imm32       = '0;
        dec.instr   = i_Instr;
        dec.src     = SRC_NONE;
        dec.illegal = 1'b0;
        unique case (i_Instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                dec.src = SRC_I;
                imm32   = {{20{i_Instr[31]}}, i_Instr[31:20]};
            end
            OPC_STORE: begin
                dec.src = SRC_S;
                imm32   = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
            end
            OPC_BRANCH: begin
                dec.src = SRC_B;
                imm32   = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7],
                           i_Instr[30:25], i_Instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                dec.src = SRC_J;
                imm32   = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12],
                           i_Instr[20], i_Instr[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.src = SRC_U;
                imm32   = {i_Instr[31:12], 12'b0};
            end
            OPC_OP: begin
                dec.src = SRC_NONE;
            end
            default: begin
                // Covers every opcode with instr[1:0] != 2'b11 as well
                dec.illegal = 1'b1;
            end
        endcase
        // Bit 31 of imm32 always equals instr[31] for non-zero formats,
        // so a signed resize gives the XLEN sign extension (U included).
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_fire  = i_Valid && o_Ready;
    assign out_fire = out_valid_q && i_Ready;

    // Next-state for output/skid registers and the illegal counter
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (!out_valid_q || i_Ready) begin
            // Output slot frees this cycle; the skid entry is older, so it goes first
            if (USE_SKID && skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (USE_SKID && in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        ready_d = !skid_valid_d;

        if (out_fire && out_q.illegal && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            out_q        <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_q       <= ENTRY_RST;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
        end
    end

    // Without the skid entry, ready must look through to downstream in the same cycle
    assign o_Ready      = USE_SKID ? ready_q : (!out_valid_q || i_Ready);
    assign o_Valid      = out_valid_q;
    assign o_Instr      = out_q.instr;
    assign o_Imm        = out_q.imm;
    assign o_ImmSrc     = out_q.src;
    assign o_Illegal    = out_q.illegal;
    assign o_IllegalCnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances
//   a: XLEN=32, skid   b: XLEN=64, skid   c: XLEN=32, no skid
module tb_imm_decode_stage;

    logic clk;
    logic rst_n;

    logic        a_vi, a_ro, a_vo, a_ri, a_ill;
    logic [31:0] a_instr, a_io, a_imm;
    logic [2:0]  a_src;
    logic [15:0] a_cnt;

    logic        b_vi, b_ro, b_vo, b_ri, b_ill;
    logic [31:0] b_instr, b_io;
    logic [63:0] b_imm;
    logic [2:0]  b_src;
    logic [15:0] b_cnt;

    logic        c_vi, c_ro, c_vo, c_ri, c_ill;
    logic [31:0] c_instr, c_io, c_imm;
    logic [2:0]  c_src;
    logic [15:0] c_cnt;

    int checks = 0;
    int errors = 0;

    imm_decode_stage #(.XLEN(32), .USE_SKID(1'b1)) u_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(a_vi), .o_Ready(a_ro), .i_Instr(a_instr),
        .o_Valid(a_vo), .i_Ready(a_ri), .o_Instr(a_io), .o_Imm(a_imm), .o_ImmSrc(a_src),
        .o_Illegal(a_ill), .o_IllegalCnt(a_cnt)
    );

    imm_decode_stage #(.XLEN(64), .USE_SKID(1'b1)) u_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(b_vi), .o_Ready(b_ro), .i_Instr(b_instr),
        .o_Valid(b_vo), .i_Ready(b_ri), .o_Instr(b_io), .o_Imm(b_imm), .o_ImmSrc(b_src),
        .o_Illegal(b_ill), .o_IllegalCnt(b_cnt)
    );

    imm_decode_stage #(.XLEN(32), .USE_SKID(1'b0)) u_c (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(c_vi), .o_Ready(c_ro), .i_Instr(c_instr),
        .o_Valid(c_vo), .i_Ready(c_ri), .o_Instr(c_io), .o_Imm(c_imm), .o_ImmSrc(c_src),
        .o_Illegal(c_ill), .o_IllegalCnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fv   [6];
    logic [31:0] fimm [6];
    logic [2:0]  fsrc [6];

    initial begin
        fv[0] = 32'hFFC12083; fimm[0] = 32'hFFFFFFFC; fsrc[0] = 3'b000;
        fv[1] = 32'hFE112E23; fimm[1] = 32'hFFFFFFFC; fsrc[1] = 3'b001;
        fv[2] = 32'hFE000CE3; fimm[2] = 32'hFFFFFFF8; fsrc[2] = 3'b010;
        fv[3] = 32'h001000EF; fimm[3] = 32'h00000800; fsrc[3] = 3'b011;
        fv[4] = 32'h800002B7; fimm[4] = 32'h80000000; fsrc[4] = 3'b100;
        fv[5] = 32'h002081B3; fimm[5] = 32'h00000000; fsrc[5] = 3'b111;

        a_vi = 0; a_ri = 1; a_instr = '0;
        b_vi = 0; b_ri = 1; b_instr = '0;
        c_vi = 0; c_ri = 1; c_instr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset state
        chk("rst_valid",  64'(a_vo),  64'h0);
        chk("rst_instr",  64'(a_io),  64'h0);
        chk("rst_imm",    64'(a_imm), 64'h0);
        chk("rst_src",    64'(a_src), 64'h7);
        chk("rst_ill",    64'(a_ill), 64'h0);
        chk("rst_cnt",    64'(a_cnt), 64'h0);
        chk("rst_ready",  64'(a_ro),  64'h1);
        chk("rst_c_ready", 64'(c_ro), 64'h1);
        #10 rst_n = 1'b1;
        tick();

        // XLEN=32 formats, back-to-back with i_Ready=1
        for (int i = 0; i < 6; i++) begin
            a_vi = 1; a_instr = fv[i];
            tick();
            chk($sformatf("fmt%0d_valid", i), 64'(a_vo), 64'h1);
            chk($sformatf("fmt%0d_imm", i),   64'(a_imm), 64'(fimm[i]));
            chk($sformatf("fmt%0d_src", i),   64'(a_src), 64'(fsrc[i]));
            chk($sformatf("fmt%0d_ill", i),   64'(a_ill), 64'h0);
        end
        a_vi = 0;
        tick();
        chk("fmt_drain_valid", 64'(a_vo), 64'h0);

        // XLEN=64
        b_vi = 1; b_instr = 32'h800002B7;
        tick();
        chk("x64_lui_imm", b_imm, 64'hFFFFFFFF80000000);
        chk("x64_lui_src", 64'(b_src), 64'h4);
        b_instr = 32'hFFC12083;
        tick();
        chk("x64_ld_imm", b_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("x64_ld_src", 64'(b_src), 64'h0);
        b_vi = 0;

        // Illegal handling
        a_vi = 1; a_instr = 32'h00000000;
        tick();
        chk("ill0_ill", 64'(a_ill), 64'h1);
        chk("ill0_src", 64'(a_src), 64'h7);
        chk("ill0_imm", 64'(a_imm), 64'h0);
        chk("ill0_cnt", 64'(a_cnt), 64'h0);
        a_instr = 32'h0000007F;
        tick();
        chk("ill1_ill", 64'(a_ill), 64'h1);
        chk("ill1_src", 64'(a_src), 64'h7);
        chk("ill1_imm", 64'(a_imm), 64'h0);
        chk("ill1_cnt", 64'(a_cnt), 64'h1);
        a_vi = 0;
        tick();
        chk("ill_both_cnt", 64'(a_cnt), 64'h2);
        chk("ill_both_valid", 64'(a_vo), 64'h0);

        // Illegal held stalled for 5 cycles counts once
        a_ri = 0; a_vi = 1; a_instr = 32'h0000007F;
        tick();
        a_vi = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_cnt", i),   64'(a_cnt), 64'h2);
            chk($sformatf("stall%0d_valid", i), 64'(a_vo),  64'h1);
            chk($sformatf("stall%0d_instr", i), 64'(a_io),  64'h7F);
            tick();
        end
        a_ri = 1;
        tick();
        chk("stall_done_cnt", 64'(a_cnt), 64'h3);
        chk("stall_done_valid", 64'(a_vo), 64'h0);

        // Backpressure with skid: A, B, C with 3 stalled cycles
        a_ri = 0;
        chk("bp_ready0", 64'(a_ro), 64'h1);
        a_vi = 1; a_instr = 32'h00100093;
        tick();
        chk("bp1_instr", 64'(a_io), 64'h00100093);
        chk("bp1_ready", 64'(a_ro), 64'h1);
        a_instr = 32'h00200093;
        tick();
        chk("bp2_instr", 64'(a_io), 64'h00100093);
        chk("bp2_ready", 64'(a_ro), 64'h0);
        a_instr = 32'h00300093;
        tick();
        chk("bp3_instr", 64'(a_io), 64'h00100093);
        chk("bp3_ready", 64'(a_ro), 64'h0);
        a_ri = 1;
        tick();
        chk("bp4_instr", 64'(a_io), 64'h00200093);
        chk("bp4_valid", 64'(a_vo), 64'h1);
        chk("bp4_ready", 64'(a_ro), 64'h1);
        tick();
        chk("bp5_instr", 64'(a_io), 64'h00300093);
        chk("bp5_imm",   64'(a_imm), 64'h3);
        a_vi = 0;
        tick();
        chk("bp6_valid", 64'(a_vo), 64'h0);

        // Reset mid-stream with output and skid both full
        a_ri = 0; a_vi = 1; a_instr = 32'h0000007F;
        tick();
        a_instr = 32'h00100093;
        tick();
        a_vi = 0;
        chk("mid_pre_ready", 64'(a_ro), 64'h0);
        chk("mid_pre_valid", 64'(a_vo), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(a_vo),  64'h0);
        chk("mid_src",   64'(a_src), 64'h7);
        chk("mid_cnt",   64'(a_cnt), 64'h0);
        chk("mid_ready", 64'(a_ro),  64'h1);
        a_ri = 1;
        #3 rst_n = 1'b1;
        tick();
        chk("mid_after_valid", 64'(a_vo), 64'h0);

        // No-skid mode: ready follows i_Ready while holding a result
        c_ri = 0; c_vi = 1; c_instr = 32'h00100093;
        tick();
        chk("ns1_valid", 64'(c_vo), 64'h1);
        chk("ns1_ready", 64'(c_ro), 64'h0);
        c_ri = 1; #1;
        chk("ns1_ready_comb_hi", 64'(c_ro), 64'h1);
        c_ri = 0; #1;
        chk("ns1_ready_comb_lo", 64'(c_ro), 64'h0);
        c_instr = 32'h00200093;
        tick();
        chk("ns2_instr", 64'(c_io), 64'h00100093);
        tick();
        chk("ns3_instr", 64'(c_io), 64'h00100093);
        c_ri = 1;
        tick();
        chk("ns4_instr", 64'(c_io), 64'h00200093);
        c_instr = 32'h00300093;
        tick();
        chk("ns5_instr", 64'(c_io), 64'h00300093);
        chk("ns5_valid", 64'(c_vo), 64'h1);
        c_vi = 0;
        tick();
        chk("ns6_valid", 64'(c_vo), 64'h0);

        // Saturation: 65537 illegal results delivered
        a_ri = 1; a_vi = 1; a_instr = 32'h00000000;
        for (int i = 1; i <= 65537; i++) begin
            tick();
            if (i == 65535) chk("sat_pre_cnt", 64'(a_cnt), 64'hFFFE);
        end
        chk("sat_at_cnt", 64'(a_cnt), 64'hFFFF);
        a_vi = 0;
        tick();
        chk("sat_last_cnt", 64'(a_cnt), 64'hFFFF);
        tick();
        tick();
        chk("sat_hold_cnt", 64'(a_cnt), 64'hFFFF);
        chk("sat_hold_valid", 64'(a_vo), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
